// File: rtl/accelerator_pkg.sv
// Shared types and defaults for the APU issue path between the core and the accelerator.
package accelerator_pkg;

    localparam int DEFAULT_DEPTH           = 4;
    localparam int DEFAULT_MAX_OUTSTANDING = 2;

    // CSR/vsetvl changes vector state, so it must not overlap with older in-flight ops.
    localparam logic [5:0] ACC_OP_VSETVL = 6'h3F;

    typedef struct packed {
        logic [2:0][31:0] operands;
        logic [5:0]       op;
        logic [14:0]      flags;
    } apu_req_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } issue_state_e;

endpackage

// File: rtl/apu_issue_queue_if.sv
// APU request/response bundle; master drives requests, slave grants and returns results.
interface apu_issue_queue_if;

    logic             req;
    logic             gnt;
    logic [2:0][31:0] operands;
    logic [5:0]       op;
    logic [14:0]      flags;
    logic             rvalid;
    logic [31:0]      result;
    logic [4:0]       rflags;

    modport master (
        output req, operands, op, flags,
        input  gnt, rvalid, result, rflags
    );

    modport slave (
        input  req, operands, op, flags,
        output gnt, rvalid, result, rflags
    );

endinterface

// File: rtl/sync_fifo.sv
// Type-parameterised synchronous FIFO with registered storage and a live entry count.
module sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic                   push,
    input  T                       wdata,
    input  logic                   pop,
    output T                       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apu_issue_queue.sv
// Decouples the core APU port from the accelerator: buffers requests, caps in-flight ops,
// drains before vsetvl and registers the return path.
module apu_issue_queue
    import accelerator_pkg::*;
#(
    parameter int DEPTH           = DEFAULT_DEPTH,
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
    input  logic                   clk,
    input  logic                   n_reset,

    input  logic                   core_apu_req_i,
    output logic                   core_apu_gnt_o,
    input  logic [2:0][31:0]       core_apu_operands_i,
    input  logic [5:0]             core_apu_op_i,
    input  logic [14:0]            core_apu_flags_i,
    output logic                   core_apu_rvalid_o,
    output logic [31:0]            core_apu_result_o,
    output logic [4:0]             core_apu_flags_o,

    output logic                   acc_apu_req_o,
    input  logic                   acc_apu_gnt_i,
    output logic [2:0][31:0]       acc_apu_operands_o,
    output logic [5:0]             acc_apu_op_o,
    output logic [14:0]            acc_apu_flags_o,
    input  logic                   acc_apu_rvalid_i,
    input  logic [31:0]            acc_apu_result_i,
    input  logic [4:0]             acc_apu_flags_i,

    output logic [$clog2(DEPTH):0] occupancy_o,
    output logic [2:0]             outstanding_o,
    output logic                   protocol_err_o
);

    localparam int         CW      = $clog2(DEPTH) + 1;
    localparam logic [2:0] MAX_OUT = 3'(MAX_OUTSTANDING);

    apu_req_t     push_data;
    apu_req_t     head;
    logic         fifo_full;
    logic         fifo_empty;
    logic [CW-1:0] fifo_count;
    logic         push;
    logic         pop;
    logic         ready_q;
    logic [2:0]   outstanding_q;
    logic         err_q;
    logic         rsp_ok;
    logic         head_is_vsetvl;
    logic         issue_ok;
    issue_state_e state_q;
    issue_state_e state_d;
    logic         rvalid_q;
    logic [31:0]  result_q;
    logic [4:0]   rflags_q;

    assign push_data = '{operands: core_apu_operands_i,
                         op:       core_apu_op_i,
                         flags:    core_apu_flags_i};

    sync_fifo #(
        .T     (apu_req_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .push    (push),
        .wdata   (push_data),
        .pop     (pop),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // ready_q keeps the grant low until the first clock after reset is released.
    assign core_apu_gnt_o = ready_q && !fifo_full;
    assign push           = core_apu_req_i && core_apu_gnt_o;
    assign head_is_vsetvl = !fifo_empty && (head.op == ACC_OP_VSETVL);

    always_comb begin
        state_d  = state_q;
        issue_ok = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (head_is_vsetvl && (outstanding_q != '0)) begin
                    state_d = ST_DRAIN;
                end else begin
                    issue_ok = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (outstanding_q == '0) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_RUN;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
        end
    end

    assign acc_apu_req_o      = !fifo_empty && (outstanding_q < MAX_OUT) && issue_ok;
    assign pop                = acc_apu_req_o && acc_apu_gnt_i;
    assign acc_apu_operands_o = head.operands;
    assign acc_apu_op_o       = head.op;
    assign acc_apu_flags_o    = head.flags;

    // A response with nothing in flight is flagged but never allowed to underflow the count.
    assign rsp_ok = acc_apu_rvalid_i && (outstanding_q != '0);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            if (acc_apu_rvalid_i && (outstanding_q == '0)) begin
                err_q <= 1'b1;
            end
            case ({pop, rsp_ok})
                2'b10:   outstanding_q <= outstanding_q + 3'd1;
                2'b01:   outstanding_q <= outstanding_q - 3'd1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rvalid_q <= 1'b0;
            result_q <= '0;
            rflags_q <= '0;
        end else begin
            rvalid_q <= acc_apu_rvalid_i;
            if (acc_apu_rvalid_i) begin
                result_q <= acc_apu_result_i;
                rflags_q <= acc_apu_flags_i;
            end
        end
    end

    assign core_apu_rvalid_o = rvalid_q;
    assign core_apu_result_o = result_q;
    assign core_apu_flags_o  = rflags_q;
    assign occupancy_o       = fifo_count;
    assign outstanding_o     = outstanding_q;
    assign protocol_err_o    = err_q;

endmodule
